// File: rtl/sdram_arbiter.sv
// Shares the single SDRAM command port between MCD212 (port A) and CDIC (port B).
// A has fixed priority; B is forced through after MAX_A_STREAK back-to-back A grants.
module sdram_arbiter #(
    parameter int unsigned MAX_A_STREAK = 4
) (
    input  logic        clk30,
    input  logic        reset,
    input  logic [24:0] a_addr,
    input  logic        a_rd,
    input  logic        a_wr,
    input  logic        a_word,
    input  logic [15:0] a_din,
    output logic [15:0] a_dout,
    output logic        a_busy,
    input  logic [24:0] b_addr,
    input  logic        b_rd,
    input  logic        b_wr,
    input  logic        b_word,
    input  logic [15:0] b_din,
    output logic [15:0] b_dout,
    output logic        b_busy,
    output logic [24:0] sdram_addr,
    output logic        sdram_rd,
    output logic        sdram_wr,
    output logic        sdram_word,
    output logic [15:0] sdram_din,
    input  logic [15:0] sdram_dout,
    input  logic        sdram_busy
);

    typedef enum logic [1:0] {IDLE, ACK, RUN} state_t;

    localparam logic [2:0] STREAK_LIMIT = 3'(MAX_A_STREAK);

    state_t      state, state_next;

    logic        a_pend, a_lrd, a_lword;
    logic [24:0] a_laddr;
    logic [15:0] a_ldin;
    logic        b_pend, b_lrd, b_lword;
    logic [24:0] b_laddr;
    logic [15:0] b_ldin;

    logic        owner_b, owner_rd;
    logic [2:0]  a_streak;

    logic        a_take, b_take, a_req, b_req;
    logic        a_eff_rd, b_eff_rd, a_eff_word, b_eff_word;
    logic [24:0] a_eff_addr, b_eff_addr;
    logic [15:0] a_eff_din, b_eff_din;
    logic        grant_a, grant_b, complete;
    logic        cmd_rd, cmd_word;
    logic [24:0] cmd_addr;
    logic [15:0] cmd_din;

    // A strobe arriving in IDLE competes directly, bypassing the latch
    always_comb begin
        a_take     = (a_rd | a_wr) & ~a_busy;
        b_take     = (b_rd | b_wr) & ~b_busy;
        a_req      = a_pend | a_take;
        b_req      = b_pend | b_take;
        a_eff_rd   = a_pend ? a_lrd   : a_rd;
        a_eff_addr = a_pend ? a_laddr : a_addr;
        a_eff_word = a_pend ? a_lword : a_word;
        a_eff_din  = a_pend ? a_ldin  : a_din;
        b_eff_rd   = b_pend ? b_lrd   : b_rd;
        b_eff_addr = b_pend ? b_laddr : b_addr;
        b_eff_word = b_pend ? b_lword : b_word;
        b_eff_din  = b_pend ? b_ldin  : b_din;
    end

    always_ff @(posedge clk30 or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_a    = 1'b0;
        grant_b    = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                if (a_req || b_req) begin
                    state_next = ACK;
                    if (a_req && !(b_req && a_streak == STREAK_LIMIT)) begin
                        grant_a = 1'b1;
                    end else begin
                        grant_b = 1'b1;
                    end
                end
            end
            ACK: begin
                if (sdram_busy) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!sdram_busy) begin
                    state_next = IDLE;
                    complete   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_rd   = grant_b ? b_eff_rd   : a_eff_rd;
        cmd_addr = grant_b ? b_eff_addr : a_eff_addr;
        cmd_word = grant_b ? b_eff_word : a_eff_word;
        cmd_din  = grant_b ? b_eff_din  : a_eff_din;
    end

    always_ff @(posedge clk30 or posedge reset) begin
        if (reset) begin
            a_pend     <= 1'b0;
            a_lrd      <= 1'b0;
            a_lword    <= 1'b0;
            a_laddr    <= '0;
            a_ldin     <= '0;
            b_pend     <= 1'b0;
            b_lrd      <= 1'b0;
            b_lword    <= 1'b0;
            b_laddr    <= '0;
            b_ldin     <= '0;
            a_busy     <= 1'b0;
            b_busy     <= 1'b0;
            a_dout     <= '0;
            b_dout     <= '0;
            owner_b    <= 1'b0;
            owner_rd   <= 1'b0;
            a_streak   <= '0;
            sdram_rd   <= 1'b0;
            sdram_wr   <= 1'b0;
            sdram_addr <= '0;
            sdram_word <= 1'b0;
            sdram_din  <= '0;
        end else begin
            sdram_rd <= 1'b0;
            sdram_wr <= 1'b0;

            if (a_take) begin
                a_lrd   <= a_rd;
                a_laddr <= a_addr;
                a_lword <= a_word;
                a_ldin  <= a_din;
                a_busy  <= 1'b1;
            end
            if (b_take) begin
                b_lrd   <= b_rd;
                b_laddr <= b_addr;
                b_lword <= b_word;
                b_ldin  <= b_din;
                b_busy  <= 1'b1;
            end
            a_pend <= a_req & ~grant_a;
            b_pend <= b_req & ~grant_b;

            if (grant_a || grant_b) begin
                sdram_rd   <= cmd_rd;
                sdram_wr   <= ~cmd_rd;
                sdram_addr <= cmd_addr;
                sdram_word <= cmd_word;
                sdram_din  <= cmd_din;
                owner_b    <= grant_b;
                owner_rd   <= cmd_rd;
                if (grant_b || !b_req) begin
                    a_streak <= '0;
                end else if (a_streak != 3'd7) begin
                    a_streak <= a_streak + 3'd1;
                end
            end

            if (complete) begin
                if (owner_b) begin
                    b_busy <= 1'b0;
                    if (owner_rd) begin
                        b_dout <= sdram_dout;
                    end
                end else begin
                    a_busy <= 1'b0;
                    if (owner_rd) begin
                        a_dout <= sdram_dout;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: expected commands and completions are queued
// by the stimulus and consumed by a negedge monitor; a small controller model answers.
module tb_sdram_arbiter;

    logic        clk30 = 1'b0;
    logic        reset;
    logic [24:0] a_addr, b_addr;
    logic        a_rd, a_wr, a_word, b_rd, b_wr, b_word;
    logic [15:0] a_din, b_din;
    logic [15:0] a_dout, b_dout;
    logic        a_busy, b_busy;
    logic [24:0] sdram_addr;
    logic        sdram_rd, sdram_wr, sdram_word;
    logic [15:0] sdram_din;
    logic [15:0] sdram_dout;
    logic        sdram_busy;

    sdram_arbiter #(.MAX_A_STREAK(4)) dut (
        .clk30      (clk30),
        .reset      (reset),
        .a_addr     (a_addr),
        .a_rd       (a_rd),
        .a_wr       (a_wr),
        .a_word     (a_word),
        .a_din      (a_din),
        .a_dout     (a_dout),
        .a_busy     (a_busy),
        .b_addr     (b_addr),
        .b_rd       (b_rd),
        .b_wr       (b_wr),
        .b_word     (b_word),
        .b_din      (b_din),
        .b_dout     (b_dout),
        .b_busy     (b_busy),
        .sdram_addr (sdram_addr),
        .sdram_rd   (sdram_rd),
        .sdram_wr   (sdram_wr),
        .sdram_word (sdram_word),
        .sdram_din  (sdram_din),
        .sdram_dout (sdram_dout),
        .sdram_busy (sdram_busy)
    );

    always #5 clk30 = ~clk30;

    typedef struct {
        logic        rd;
        logic [24:0] addr;
        logic        word;
        logic [15:0] din;
        int          cyc;
    } cmd_t;

    cmd_t        exp_cmd[$];
    logic [15:0] a_exp[$];
    logic [15:0] b_exp[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int cmds_seen   = 0;
    int fall_cyc    = -100;
    int ctl_len     = 5;

    always @(posedge clk30) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic flag(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic logic [15:0] rdata_of(input logic [24:0] addr);
        return addr[15:0] + 16'h1134;
    endfunction

    task automatic push_cmd(input logic rd, input logic [24:0] addr, input logic word,
                            input logic [15:0] din, input int c);
        exp_cmd.push_back('{rd: rd, addr: addr, word: word, din: din, cyc: c});
    endtask

    task automatic strobe_a(input logic rd, input logic wr, input logic [24:0] addr,
                            input logic word, input logic [15:0] din);
        a_rd = rd; a_wr = wr; a_addr = addr; a_word = word; a_din = din;
        @(negedge clk30);
        a_rd = 1'b0; a_wr = 1'b0;
    endtask

    task automatic strobe_b(input logic rd, input logic wr, input logic [24:0] addr,
                            input logic word, input logic [15:0] din);
        b_rd = rd; b_wr = wr; b_addr = addr; b_word = word; b_din = din;
        @(negedge clk30);
        b_rd = 1'b0; b_wr = 1'b0;
    endtask

    task automatic wait_idle(input bit port_b, input string tag);
        int n = 0;
        do begin
            @(negedge clk30);
            n++;
        end while ((port_b ? b_busy : a_busy) && n < 400);
        if (port_b ? b_busy : a_busy) flag({tag, "_busy_timeout"});
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_a_port"},    32'({a_busy, a_dout}), 32'h0);
        chk({tag, "_b_port"},    32'({b_busy, b_dout}), 32'h0);
        chk({tag, "_sdram_ctl"}, 32'({sdram_rd, sdram_wr, sdram_word, sdram_addr}), 32'h0);
        chk({tag, "_sdram_din"}, 32'(sdram_din), 32'h0);
    endtask

    // Controller model: busy rises one cycle after the strobe, stays high ctl_len cycles
    initial begin
        logic        ctl_rd;
        logic [24:0] ctl_addr;
        int          ctl_phase, ctl_cnt;
        ctl_rd = 1'b0; ctl_addr = '0; ctl_phase = 0; ctl_cnt = 0;
        sdram_busy = 1'b0;
        sdram_dout = 16'h0;
        forever begin
            @(posedge clk30);
            #1;
            if (reset) begin
                ctl_phase  = 0;
                sdram_busy = 1'b0;
            end else begin
                case (ctl_phase)
                    0: if (sdram_rd || sdram_wr) begin
                        ctl_rd    = sdram_rd;
                        ctl_addr  = sdram_addr;
                        ctl_phase = 1;
                    end
                    1: begin
                        sdram_busy = 1'b1;
                        ctl_cnt    = ctl_len;
                        ctl_phase  = 2;
                    end
                    default: begin
                        ctl_cnt--;
                        if (ctl_cnt == 0) begin
                            sdram_busy = 1'b0;
                            sdram_dout = ctl_rd ? rdata_of(ctl_addr) : 16'hDEAD;
                            ctl_phase  = 0;
                        end
                    end
                endcase
            end
        end
    end

    initial begin
        logic        p_a_busy, p_b_busy, p_strobe, p_sbusy, inflight;
        cmd_t        e;
        logic [15:0] d;
        p_a_busy = 1'b0; p_b_busy = 1'b0; p_strobe = 1'b0; p_sbusy = 1'b0; inflight = 1'b0;
        forever begin
            @(negedge clk30);
            if (reset) begin
                p_a_busy = 1'b0; p_b_busy = 1'b0; p_strobe = 1'b0; p_sbusy = 1'b0;
                inflight = 1'b0;
                continue;
            end
            if (sdram_rd || sdram_wr) begin
                cmds_seen++;
                chk("rd_wr_exclusive", 32'(sdram_rd & sdram_wr), 32'h0);
                chk("strobe_one_cycle", 32'(p_strobe), 32'h0);
                chk("no_overlap", 32'(inflight), 32'h0);
                inflight = 1'b1;
                if (exp_cmd.size() == 0) begin
                    flag("unexpected_sdram_command");
                end else begin
                    e = exp_cmd.pop_front();
                    chk("cmd_rd", 32'(sdram_rd), 32'(e.rd));
                    chk("cmd_addr", 32'(sdram_addr), 32'(e.addr));
                    chk("cmd_word", 32'(sdram_word), 32'(e.word));
                    if (!e.rd) chk("cmd_din", 32'(sdram_din), 32'(e.din));
                    if (e.cyc >= 0) chk("cmd_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (p_sbusy && !sdram_busy) fall_cyc = cyc;
            if (p_a_busy && !a_busy) begin
                inflight = 1'b0;
                chk("a_done_latency", 32'(cyc), 32'(fall_cyc + 1));
                if (a_exp.size() == 0) begin
                    flag("unexpected_a_completion");
                end else begin
                    d = a_exp.pop_front();
                    chk("a_dout", 32'(a_dout), 32'(d));
                end
            end
            if (p_b_busy && !b_busy) begin
                inflight = 1'b0;
                chk("b_done_latency", 32'(cyc), 32'(fall_cyc + 1));
                if (b_exp.size() == 0) begin
                    flag("unexpected_b_completion");
                end else begin
                    d = b_exp.pop_front();
                    chk("b_dout", 32'(b_dout), 32'(d));
                end
            end
            p_a_busy = a_busy;
            p_b_busy = b_busy;
            p_strobe = sdram_rd | sdram_wr;
            p_sbusy  = sdram_busy;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, n;
        reset = 1'b1;
        a_rd = 1'b0; a_wr = 1'b0; a_word = 1'b0; a_addr = '0; a_din = '0;
        b_rd = 1'b0; b_wr = 1'b0; b_word = 1'b0; b_addr = '0; b_din = '0;
        repeat (3) @(negedge clk30);
        check_outputs_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk30);

        // Single A read, 5 busy cycles
        ctl_len = 5;
        push_cmd(1'b1, 25'h100, 1'b1, 16'h0, cyc + 1);
        a_exp.push_back(16'h1234);
        strobe_a(1'b1, 1'b0, 25'h100, 1'b1, 16'h0);
        chk("t1_a_busy_at_issue", 32'(a_busy), 32'h1);
        wait_idle(1'b0, "t1");
        repeat (2) @(negedge clk30);

        // Simultaneous A read and B write: B issues the cycle after A completes
        push_cmd(1'b1, 25'h10, 1'b1, 16'h0, cyc + 1);
        push_cmd(1'b0, 25'h20, 1'b1, 16'hBEEF, cyc + 9);
        a_exp.push_back(16'h1144);
        b_exp.push_back(16'h0000);
        fork
            strobe_a(1'b1, 1'b0, 25'h10, 1'b1, 16'h0);
            strobe_b(1'b0, 1'b1, 25'h20, 1'b1, 16'hBEEF);
        join
        chk("t2_b_busy_queued", 32'(b_busy), 32'h1);
        wait_idle(1'b0, "t2a");
        chk("t2_b_busy_held", 32'(b_busy), 32'h1);
        wait_idle(1'b1, "t2b");
        repeat (2) @(negedge clk30);

        // Starvation guard: A x4, B, A x4, B, A
        ctl_len = 2;
        for (int k = 0; k < 4; k++) push_cmd(1'b1, 25'h1000 + 25'(k), 1'b1, 16'h0, -1);
        push_cmd(1'b1, 25'h2000, 1'b1, 16'h0, -1);
        for (int k = 4; k < 8; k++) push_cmd(1'b1, 25'h1000 + 25'(k), 1'b1, 16'h0, -1);
        push_cmd(1'b1, 25'h2001, 1'b1, 16'h0, -1);
        push_cmd(1'b1, 25'h1008, 1'b1, 16'h0, -1);
        for (int k = 0; k < 9; k++) a_exp.push_back(16'h2134 + 16'(k));
        b_exp.push_back(16'h3134);
        b_exp.push_back(16'h3135);
        fork
            begin
                strobe_a(1'b1, 1'b0, 25'h1000, 1'b1, 16'h0);
                for (int k = 1; k < 9; k++) begin
                    wait_idle(1'b0, "t3a");
                    strobe_a(1'b1, 1'b0, 25'h1000 + 25'(k), 1'b1, 16'h0);
                end
                wait_idle(1'b0, "t3a_last");
            end
            begin
                strobe_b(1'b1, 1'b0, 25'h2000, 1'b1, 16'h0);
                wait_idle(1'b1, "t3b");
                strobe_b(1'b1, 1'b0, 25'h2001, 1'b1, 16'h0);
                wait_idle(1'b1, "t3b_last");
            end
        join
        repeat (2) @(negedge clk30);

        // Write strobe while A is busy must be dropped
        ctl_len = 4;
        n0 = cmds_seen;
        push_cmd(1'b1, 25'h300, 1'b1, 16'h0, cyc + 1);
        a_exp.push_back(16'h1434);
        strobe_a(1'b1, 1'b0, 25'h300, 1'b1, 16'h0);
        @(negedge clk30);
        strobe_a(1'b0, 1'b1, 25'h304, 1'b1, 16'h5555);
        wait_idle(1'b0, "t4");
        repeat (6) @(negedge clk30);
        chk("t4_single_command", 32'(cmds_seen - n0), 32'h1);

        // Reset while the controller is mid-transaction
        ctl_len = 6;
        push_cmd(1'b1, 25'h400, 1'b1, 16'h0, cyc + 1);
        strobe_a(1'b1, 1'b0, 25'h400, 1'b1, 16'h0);
        n = 0;
        while (!sdram_busy && n < 50) begin
            @(negedge clk30);
            n++;
        end
        if (!sdram_busy) flag("t5_controller_busy_timeout");
        repeat (2) @(negedge clk30);
        chk("t5_a_busy_in_run", 32'(a_busy), 32'h1);
        #2 reset = 1'b1;
        #1 check_outputs_zero("t5_async_reset");
        repeat (2) @(negedge clk30);
        reset = 1'b0;
        @(negedge clk30);
        ctl_len = 3;
        push_cmd(1'b1, 25'h500, 1'b1, 16'h0, cyc + 1);
        b_exp.push_back(16'h1634);
        strobe_b(1'b1, 1'b0, 25'h500, 1'b1, 16'h0);
        wait_idle(1'b1, "t5b");
        repeat (2) @(negedge clk30);

        // Byte write on B leaves both read registers alone
        push_cmd(1'b1, 25'h700, 1'b1, 16'h0, cyc + 1);
        a_exp.push_back(16'h1834);
        strobe_a(1'b1, 1'b0, 25'h700, 1'b1, 16'h0);
        wait_idle(1'b0, "t6a");
        @(negedge clk30);
        push_cmd(1'b0, 25'h601, 1'b0, 16'h00AB, cyc + 1);
        b_exp.push_back(16'h1634);
        strobe_b(1'b0, 1'b1, 25'h601, 1'b0, 16'h00AB);
        wait_idle(1'b1, "t6b");
        chk("t6_a_dout_unchanged", 32'(a_dout), 32'h1834);

        repeat (5) @(negedge clk30);
        chk("cmd_queue_drained", 32'(exp_cmd.size()), 32'h0);
        chk("a_queue_drained", 32'(a_exp.size()), 32'h0);
        chk("b_queue_drained", 32'(b_exp.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
